spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================
// spi_pkg : shared FSM state type and byte width for spi_slave.
// Rev 1.0
// ============================================================
package spi_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================
// spi_sync : STAGES-deep flop chain bringing one async input into clk.
// Rev 1.0
// ============================================================
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================
// spi_slave : SPI mode-0 slave, CS/SCK/MOSI oversampled on CLK.
// Option macro SPI_SLAVE_OVERRUN_EN enables the sticky OVR flag.
// Rev 1.0
// ============================================================
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [BYTE_W-1:0] DOUT,
  input  logic              LOAD,
  output logic [BYTE_W-1:0] DIN,
  output logic              VALID,
  input  logic              ACK,
  output logic              BUSY,
  output logic              OVR
);

  localparam logic [1:0] c_SETTLE = 2'(SYNC_STAGES);

  logic w_cs_s, w_sck_s, w_mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(CLK), .i_rst_n(RST_N), .i_d(CS), .o_q(w_cs_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .i_clk(CLK), .i_rst_n(RST_N), .i_d(SCK), .o_q(w_sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(CLK), .i_rst_n(RST_N), .i_d(MOSI), .o_q(w_mosi_s));

  state_t            r_state, w_state_nxt;
  logic              r_cs_d, r_sck_d, r_armed;
  logic [1:0]        r_settle;
  logic [BYTE_W-1:0] r_tx, r_hold, r_din;
  logic [BYTE_W-2:0] r_rx;
  logic [2:0]        r_cnt;
  logic              r_byte_end, r_valid;
  logic              w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
  logic              w_reload, w_shift_tx, w_sample, w_abort;

  // The chain holds its reset value for SYNC_STAGES cycles; only a CS high
  // observed after that arms frame detection, so a frame cut by reset is ignored.
  assign w_cs_fall  = r_cs_d & ~w_cs_s & r_armed;
  assign w_cs_rise  = ~r_cs_d & w_cs_s;
  assign w_sck_rise = ~r_sck_d & w_sck_s;
  assign w_sck_fall = r_sck_d & ~w_sck_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    w_shift_tx  = 1'b0;
    w_sample    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_reload    = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else begin
          w_sample = w_sck_rise;
          if (w_sck_fall) begin
            w_reload   = r_byte_end;
            w_shift_tx = ~r_byte_end;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cs_d     <= 1'b1;
      r_sck_d    <= 1'b0;
      r_armed    <= 1'b0;
      r_settle   <= 2'd0;
      r_tx       <= '0;
      r_hold     <= '0;
      r_rx       <= '0;
      r_din      <= '0;
      r_cnt      <= 3'd0;
      r_byte_end <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_cs_d  <= w_cs_s;
      r_sck_d <= w_sck_s;
      r_valid <= 1'b0;
      if (r_settle != c_SETTLE) begin
        r_settle <= r_settle + 2'd1;
      end else if (w_cs_s) begin
        r_armed <= 1'b1;
      end

      // A LOAD landing on a reload bypasses the holding register.
      if (w_reload) begin
        r_tx   <= LOAD ? DOUT : r_hold;
        r_hold <= '0;
      end else begin
        if (w_shift_tx) r_tx <= {r_tx[BYTE_W-2:0], 1'b0};
        if (LOAD) r_hold <= DOUT;
      end

      if (w_abort) begin
        r_cnt      <= 3'd0;
        r_byte_end <= 1'b0;
      end else if (w_sample) begin
        r_rx       <= {r_rx[BYTE_W-3:0], w_mosi_s};
        r_cnt      <= r_cnt + 3'd1;
        r_byte_end <= (r_cnt == 3'd7);
        if (r_cnt == 3'd7) begin
          r_din   <= {r_rx, w_mosi_s};
          r_valid <= 1'b1;
        end
      end else if (w_reload) begin
        r_byte_end <= 1'b0;
      end
    end
  end

  assign MISO  = (r_state == SHIFT) ? r_tx[BYTE_W-1] : 1'b0;
  assign DIN   = r_din;
  assign VALID = r_valid;
  assign BUSY  = ~w_cs_s;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_unack, r_ovr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_unack <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_valid) begin
      if (r_unack && !ACK) r_ovr <= 1'b1;
      r_unack <= 1'b1;
    end else if (ACK) begin
      r_unack <= 1'b0;
    end
  end

  assign OVR = r_ovr;
`else
  logic w_unused_ack;
  assign w_unused_ack = ACK;
  assign OVR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// Bench for spi_slave: bit-level SPI master, queue-based byte model and
// a per-cycle output checker.
module tb_spi_slave;
  localparam int SYNC = 2;
  localparam int H    = 6;

  logic       CLK = 1'b0, RST_N = 1'b0, CS = 1'b1, SCK = 1'b0, MOSI = 1'b0;
  logic       LOAD = 1'b0, ACK = 1'b0;
  logic [7:0] DOUT = 8'h00;
  logic       MISO, VALID, BUSY, OVR;
  logic [7:0] DIN;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
    .DOUT(DOUT), .LOAD(LOAD), .DIN(DIN), .VALID(VALID), .ACK(ACK),
    .BUSY(BUSY), .OVR(OVR));

  always #5 CLK = ~CLK;

  int         checks = 0, errors = 0;
  int         n_valid = 0, idle_cnt = 0, nv0 = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_din = 8'h00, m_hold = 8'h00, m_slot = 8'h00;
  logic [7:0] g, g1, g2;
  logic       m_frame_ok = 1'b0, exp_ovr = 1'b0, m_unack = 1'b0;
  logic       prev_valid = 1'b0;
  logic [SYNC-1:0] cs_hist = '1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Per-cycle checker: BUSY from CS delayed by the synchronizer depth,
  // DIN/VALID from the expected-byte queue, OVR from the ack rule.
  always begin
    @(posedge CLK);
    #1;
    if (!RST_N) begin
      cs_hist    = '1;
      exp_din    = 8'h00;
      exp_ovr    = 1'b0;
      m_unack    = 1'b0;
      prev_valid = 1'b0;
      idle_cnt   = 0;
    end else begin
      cs_hist = {cs_hist[SYNC-2:0], CS};
      chk("busy", {31'd0, BUSY}, {31'd0, ~cs_hist[SYNC-1]});
`ifdef SPI_SLAVE_OVERRUN_EN
      if (prev_valid) begin
        if (m_unack && !ACK) exp_ovr = 1'b1;
        m_unack = 1'b1;
      end else if (ACK) begin
        m_unack = 1'b0;
      end
`endif
      chk("ovr", {31'd0, OVR}, {31'd0, exp_ovr});
      if (VALID) begin
        n_valid++;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_width actual=2+cycles required=1");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL valid_unexpected actual=1 required=0 din=%0h", DIN);
        end else begin
          exp_din = exp_q.pop_front();
        end
      end
      prev_valid = VALID;
      chk("din", {24'd0, DIN}, {24'd0, exp_din});
      if (idle_cnt >= 2) chk("miso_idle", {31'd0, MISO}, 32'd0);
      idle_cnt = BUSY ? 0 : idle_cnt + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic slot_start();
    m_slot = m_hold;
    m_hold = 8'h00;
  endtask

  task automatic do_load(input logic [7:0] v);
    DOUT = v;
    LOAD = 1'b1;
    cyc(1);
    LOAD   = 1'b0;
    m_hold = v;
  endtask

  task automatic do_reset();
    RST_N      = 1'b0;
    m_hold     = 8'h00;
    m_frame_ok = 1'b0;
    exp_q.delete();
    cyc(2);
    chk("rst_din", {24'd0, DIN}, 32'd0);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_ovr", {31'd0, OVR}, 32'd0);
    RST_N = 1'b1;
    cyc(2 * H);
  endtask

  task automatic frame_begin();
    CS         = 1'b0;
    m_frame_ok = 1'b1;
    slot_start();
    cyc(H);
  endtask

  task automatic frame_end();
    cyc(H);
    CS = 1'b1;
    cyc(3 * H);
    chk("pending_valid", exp_q.size(), 32'd0);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits, input bit ld,
                           input logic [7:0] ldv, input bit ack, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = d[7-i];
      cyc(H);
      got = {got[6:0], MISO};
      SCK = 1'b1;
      if (ld && i == 3) do_load(ldv);
      else cyc(1);
      if (ack && i == 5) begin
        ACK = 1'b1;
        cyc(1);
        ACK = 1'b0;
      end else begin
        cyc(1);
      end
      cyc(H - 2);
      SCK = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit ld, input logic [7:0] ldv,
                           input bit ack, output logic [7:0] got);
    logic [7:0] slot;
    bit         ok;
    slot = m_frame_ok ? m_slot : 8'h00;
    ok   = m_frame_ok;
    if (ok) exp_q.push_back(d);
    send_bits(d, 8, ld, ldv, ack, got);
    chk("miso_byte", {24'd0, got}, {24'd0, slot});
    if (ok) slot_start();
  endtask

  initial begin
    do_reset();

    // Single byte with a preloaded reply
    do_load(8'hA5);
    nv0 = n_valid;
    frame_begin();
    send_byte(8'h3C, 0, 8'h00, 0, g);
    frame_end();
    chk("t1_miso", {24'd0, g}, 32'hA5);
    chk("t1_din", {24'd0, DIN}, 32'h3C);
    chk("t1_valid_cnt", n_valid - nv0, 32'd1);

    // Two back-to-back bytes, second reply loaded mid-frame
    do_load(8'h55);
    frame_begin();
    send_byte(8'h01, 1, 8'hAA, 0, g1);
    chk("t2_din0", {24'd0, DIN}, 32'h01);
    send_byte(8'hFF, 0, 8'h00, 0, g2);
    frame_end();
    chk("t2_miso0", {24'd0, g1}, 32'h55);
    chk("t2_miso1", {24'd0, g2}, 32'hAA);
    chk("t2_din1", {24'd0, DIN}, 32'hFF);

    // Nothing loaded: slave sends zeros
    frame_begin();
    send_byte(8'hC3, 0, 8'h00, 0, g);
    frame_end();
    chk("t3_miso", {24'd0, g}, 32'h00);
    chk("t3_din", {24'd0, DIN}, 32'hC3);

    // Abort after 5 bits, then a clean frame
    nv0 = n_valid;
    frame_begin();
    send_bits(8'hF0, 5, 0, 8'h00, 0, g);
    frame_end();
    chk("t4_din_hold", {24'd0, DIN}, 32'hC3);
    chk("t4_no_valid", n_valid - nv0, 32'd0);
    frame_begin();
    send_byte(8'h81, 0, 8'h00, 0, g);
    frame_end();
    chk("t4_din", {24'd0, DIN}, 32'h81);

    // Reset mid-frame: remainder of that frame must be ignored
    frame_begin();
    send_bits(8'hE0, 3, 0, 8'h00, 0, g);
    do_reset();
    nv0 = n_valid;
    send_bits(8'hE0, 5, 0, 8'h00, 0, g);
    send_byte(8'h5A, 0, 8'h00, 0, g);
    frame_end();
    chk("t5_no_valid", n_valid - nv0, 32'd0);
    chk("t5_din", {24'd0, DIN}, 32'h00);
    frame_begin();
    send_byte(8'h7E, 0, 8'h00, 0, g);
    frame_end();
    chk("t5_din_after", {24'd0, DIN}, 32'h7E);

    // Overrun: two unacknowledged bytes, then with an ACK between
    do_reset();
    frame_begin();
    send_byte(8'h11, 0, 8'h00, 0, g);
    send_byte(8'h22, 0, 8'h00, 0, g);
    frame_end();
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("t6_ovr_noack", {31'd0, OVR}, 32'd1);
`else
    chk("t6_ovr_noack", {31'd0, OVR}, 32'd0);
`endif
    do_reset();
    frame_begin();
    send_byte(8'h11, 0, 8'h00, 0, g);
    send_byte(8'h22, 0, 8'h00, 1, g);
    frame_end();
    chk("t6_ovr_ack", {31'd0, OVR}, 32'd0);

    // Randomized frames
    do_reset();
    for (int f = 0; f < 40; f++) begin : rnd
      int nb;
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
      frame_begin();
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1 && $urandom_range(0, 4) == 0)
          send_bits(8'($urandom), $urandom_range(1, 7), 0, 8'h00,
                    1'($urandom_range(0, 1)), g);
        else
          send_byte(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), g);
      end
      frame_end();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
